raster_sweep_ctrl: RTL and testbench
====================================

# raster_sweep_ctrl

Parametrised pixel-sweep controller for the VGA frame-buffer path: on request it walks either the whole screen (CLEAR) or a clipped rectangle (FILL) one pixel per cycle, presenting coordinate, colour and a plot strobe to the frame-buffer writer. It contains its own X/Y counters, clipping and back-pressure handling. It replaces the external-counter controllers between the user-input logic and the VGA adapter write port.

## Interface
- XW, 9, X coordinate width
- YW, 8, Y coordinate width
- CW, 3, colour width
- SCREEN_W, 160, screen width in pixels (≤ 2^XW)
- SCREEN_H, 120, screen height in pixels (≤ 2^YW)

- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request pulse/level; sampled only in IDLE
- Mode  in  1  0 = CLEAR (full screen, BgColor), 1 = FILL (rectangle, Color)
- X0  in  XW  FILL origin X
- Y0  in  YW  FILL origin Y
- W  in  XW  FILL width in pixels
- H  in  YW  FILL height in pixels
- Color  in  CW  FILL colour
- BgColor  in  CW  CLEAR colour
- Abort  in  1  terminate current sweep
- Stall  in  1  writer back-pressure; pixel accepted when Plot=1 and Stall=0
- X  out  XW  current pixel X
- Y  out  YW  current pixel Y
- ColorOut  out  CW  current pixel colour
- Plot  out  1  X/Y/ColorOut valid
- Busy  out  1  sweep in progress
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE: Plot=0, Busy=0. On Start=1: latch Mode, colour and computed bounds; go to SWEEP, or DONE directly if region empty. Operands are ignored after latching.
- Bounds, CLEAR: xs=0, ys=0, xe=SCREEN_W-1, ye=SCREEN_H-1.
- Bounds, FILL: sums computed in XW+1 / YW+1 bits. xe=min(X0+W-1, SCREEN_W-1), ye=min(Y0+H-1, SCREEN_H-1).
- Empty region: W=0, H=0, X0≥SCREEN_W or Y0≥SCREEN_H.
- SWEEP: Plot=1, Busy=1. (X,Y) starts at (xs,ys). Order is row-major, X fastest.
- SWEEP with Stall=1: everything holds.
- SWEEP accept at X<xe: X+1.
- SWEEP accept at X=xe, Y<ye: X=xs and Y+1 in the same cycle; no row-advance bubble.
- SWEEP accept at X=xe, Y=ye: go to DONE.
- DONE: Done=1, Plot=0, Busy=0 for exactly one cycle, then IDLE. Start in DONE is ignored.
- Abort=1 in SWEEP: go to DONE next edge. The current pixel is not counted as accepted, even if Stall=0 in that cycle. Abort in IDLE/DONE has no effect.
- Start while Busy is ignored; no queueing.
- ColorOut = BgColor_latched in CLEAR, Color_latched in FILL.
- Reset (any time, including mid-sweep): state IDLE, X=0, Y=0, ColorOut=0, Plot=0, Busy=0, Done=0. Latched operands cleared.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Start sampled at edge E0. First Plot with (xs,ys) is visible after E0, i.e. 1-cycle latency.
- N pixels with no stall: Plot high exactly N cycles, Done high in cycle N+1 after E0, IDLE after that. Next Start is accepted at the edge ending the DONE cycle +1.
- Each Stall cycle adds exactly one cycle; X/Y/ColorOut stable while Plot=1 and Stall=1.
- Empty region: Done high the cycle after E0; Plot never asserted.
- Reset deassertion is synchronised externally; the first edge after deassertion may sample Start.

## Test plan
- CLEAR, SCREEN 160×120, BgColor=3'b000, Stall=0 → 19200 plots, first (0,0), last (159,119), rows contiguous with no gap. Done 19201 cycles after Start. Busy low on Done.
- FILL X0=5, Y0=5, W=10, H=40, Color=3'b101 → 400 plots, first (5,5), (14,5) followed directly by (5,6), last (14,44). Every ColorOut=3'b101.
- Clipping: FILL X0=155, Y0=118, W=10, H=10 → 10 plots covering (155..159, 118..119). FILL X0=200 or W=0 → zero plots, Done 1 cycle after Start.
- Back-pressure: FILL 3×2 with Stall high 2 cycles on the 2nd pixel and 1 cycle on the last → (1,0) held 3 cycles, still 6 accepted pixels, Done at cycle 10.
- Abort after 7 accepted pixels of CLEAR → Done next cycle, Plot low. A new Start with FILL is then accepted normally, and Start during Busy is ignored.
- Async Reset asserted mid-sweep between edges → all outputs 0 immediately, without waiting for Clock. After release, IDLE; a fresh Start restarts from (xs,ys).

Source files
------------

// File: rtl/raster_sweep_ctrl.sv
// Pixel-sweep controller: walks the whole screen (CLEAR) or a clipped rectangle (FILL), one pixel per cycle.
// All outputs registered, 1-cycle start latency; Stall freezes the current pixel, Abort ends via DONE.
`timescale 1ns/1ps
module raster_sweep_ctrl #(
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int CW       = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mode,
  input  logic [XW-1:0] X0,
  input  logic [YW-1:0] Y0,
  input  logic [XW-1:0] W,
  input  logic [YW-1:0] H,
  input  logic [CW-1:0] Color,
  input  logic [CW-1:0] BgColor,
  input  logic          Abort,
  input  logic          Stall,
  output logic [XW-1:0] X,
  output logic [YW-1:0] Y,
  output logic [CW-1:0] ColorOut,
  output logic          Plot,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  localparam logic [XW:0]   SCR_W  = (XW+1)'(SCREEN_W);
  localparam logic [YW:0]   SCR_H  = (YW+1)'(SCREEN_H);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  state_t        state, state_nxt;
  logic [XW-1:0] xs_q, xe_q;
  logic [YW-1:0] ye_q;

  logic [XW:0]   x_end_sum;
  logic [YW:0]   y_end_sum;
  logic [XW-1:0] ld_xs, ld_xe;
  logic [YW-1:0] ld_ys, ld_ye;
  logic [CW-1:0] ld_col;
  logic          fill_empty, req_empty;
  logic          last_x, last_y, accept;

  // One extra bit so X0+W-1 cannot wrap before clipping against the screen edge.
  assign x_end_sum  = {1'b0, X0} + {1'b0, W} - (XW+1)'(1);
  assign y_end_sum  = {1'b0, Y0} + {1'b0, H} - (YW+1)'(1);
  assign fill_empty = (W == '0) || (H == '0) || ({1'b0, X0} >= SCR_W) || ({1'b0, Y0} >= SCR_H);
  assign req_empty  = Mode && fill_empty;

  assign ld_xs  = Mode ? X0 : '0;
  assign ld_ys  = Mode ? Y0 : '0;
  assign ld_xe  = !Mode ? X_LAST : ((x_end_sum >= SCR_W) ? X_LAST : x_end_sum[XW-1:0]);
  assign ld_ye  = !Mode ? Y_LAST : ((y_end_sum >= SCR_H) ? Y_LAST : y_end_sum[YW-1:0]);
  assign ld_col = Mode ? Color : BgColor;

  assign last_x = (X == xe_q);
  assign last_y = (Y == ye_q);
  // Abort wins over acceptance: an aborted pixel never counts as written.
  assign accept = !Stall && !Abort;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = req_empty ? S_DONE : S_SWEEP;
      S_SWEEP: if (Abort || (accept && last_x && last_y)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Plot = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      S_SWEEP: begin
        Plot = 1'b1;
        Busy = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: begin end
    endcase
  end

  // ColorOut doubles as the latched sweep colour.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      X        <= '0;
      Y        <= '0;
      ColorOut <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          X        <= ld_xs;
          Y        <= ld_ys;
          ColorOut <= ld_col;
          xs_q     <= ld_xs;
          xe_q     <= ld_xe;
          ye_q     <= ld_ye;
        end
        S_SWEEP: begin
          if (accept && !last_x) begin
            X <= X + XW'(1);
          end else if (accept && !last_y) begin
            X <= xs_q;
            Y <= Y + YW'(1);
          end
        end
        default: begin end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_sweep_ctrl.sv
// Randomised scoreboard bench for raster_sweep_ctrl: a reference model queues expected pixels and Done
// markers per request; a negedge monitor pops them as the DUT accepts pixels or pulses Done.
`timescale 1ns/1ps
module tb_raster_sweep_ctrl;

  localparam int XW = 9, YW = 8, CW = 3, SW = 160, SH = 120;

  logic          Clock = 1'b0, Reset = 1'b1;
  logic          Start = 1'b0, Mode = 1'b0, Abort = 1'b0, Stall = 1'b0;
  logic [XW-1:0] X0 = '0, W = '0;
  logic [YW-1:0] Y0 = '0, H = '0;
  logic [CW-1:0] Color = '0, BgColor = '0;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic [CW-1:0] ColorOut;
  logic          Plot, Busy, Done;

  int checks = 0, errors = 0;

  typedef struct {bit done; int x; int y; int c;} exp_t;
  exp_t sb[$];

  always #5 Clock = ~Clock;

  raster_sweep_ctrl #(.XW(XW), .YW(YW), .CW(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
    .X0(X0), .Y0(Y0), .W(W), .H(H), .Color(Color), .BgColor(BgColor),
    .Abort(Abort), .Stall(Stall),
    .X(X), .Y(Y), .ColorOut(ColorOut), .Plot(Plot), .Busy(Busy), .Done(Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: at (%0d,%0d) with no expectation queued (t=%0t)", name, X, Y, $time);
  endtask

  // Reference: enumerate the clipped rectangle row by row, keep the first abort_after pixels.
  task automatic push_req(input bit mode, input int x0, input int y0, input int w, input int h,
                          input int col, input int bg, input int abort_after, output int n);
    int xs, ys, xe, ye, c;
    bit empty;
    exp_t e;
    if (!mode) begin
      xs = 0; ys = 0; xe = SW - 1; ye = SH - 1; c = bg; empty = 0;
    end else begin
      xs = x0; ys = y0; c = col;
      xe = (x0 + w - 1 < SW - 1) ? x0 + w - 1 : SW - 1;
      ye = (y0 + h - 1 < SH - 1) ? y0 + h - 1 : SH - 1;
      empty = (w == 0) || (h == 0) || (x0 >= SW) || (y0 >= SH);
    end
    n = 0;
    if (!empty)
      for (int yy = ys; yy <= ye; yy++)
        for (int xx = xs; xx <= xe; xx++)
          if (abort_after < 0 || n < abort_after) begin
            e.done = 0; e.x = xx; e.y = yy; e.c = c;
            sb.push_back(e);
            n++;
          end
    e.done = 1; e.x = 0; e.y = 0; e.c = 0;
    sb.push_back(e);
  endtask

  // Monitor
  bit            prev_hold = 0;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [CW-1:0] pc;
  always @(negedge Clock) begin
    exp_t e;
    if (Reset) begin
      prev_hold = 0;
    end else begin
      check("busy_eq_plot", Busy, Plot);
      if (prev_hold && Plot) begin
        check("hold_x", X, px);
        check("hold_y", Y, py);
        check("hold_color", ColorOut, pc);
      end
      if (Plot && !Stall && !Abort) begin
        if (sb.size() == 0) fail_now("unexpected_plot");
        else begin
          e = sb.pop_front();
          check("pixel_not_done_slot", e.done, 0);
          check("pixel_x", X, e.x);
          check("pixel_y", Y, e.y);
          check("pixel_color", ColorOut, e.c);
        end
      end
      if (Done) begin
        check("done_plot_low", Plot, 0);
        if (sb.size() == 0) fail_now("unexpected_done");
        else begin
          e = sb.pop_front();
          check("done_slot", e.done, 1);
        end
      end
      prev_hold = Plot && Stall && !Abort;
      px = X; py = Y; pc = ColorOut;
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_req(input bit mode, input int x0, input int y0, input int w, input int h,
                         input int col, input int bg, input int pct, input int abort_after,
                         input int st1_idx, input int st1_n, input int st2_idx, input int st2_n);
    int n, cyc, stalls, acc, held, budget;
    int aborted;
    push_req(mode, x0, y0, w, h, col, bg, abort_after, n);
    Mode = mode; X0 = XW'(x0); Y0 = YW'(y0); W = XW'(w); H = YW'(h);
    Color = CW'(col); BgColor = CW'(bg);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    cyc = 1; stalls = 0; acc = 0; held = 0; aborted = 0;
    budget = 4 * n + 20;
    while (!Done && cyc <= budget) begin
      Mode = 1'($urandom); X0 = XW'($urandom); Y0 = YW'($urandom);
      W = XW'($urandom); H = YW'($urandom); Color = CW'($urandom); BgColor = CW'($urandom);
      Start = ($urandom_range(3) == 0);
      Abort = 1'b0; Stall = 1'b0;
      if (Plot) begin
        if (abort_after >= 0 && acc == abort_after) begin
          Abort = 1'b1; aborted = 1;
        end else begin
          if (st1_idx >= 0) Stall = (acc == st1_idx && held < st1_n) || (acc == st2_idx && held < st2_n);
          else              Stall = ($urandom_range(99) < pct);
          if (Stall) begin stalls++; held++; end
          else begin acc++; held = 0; end
        end
      end
      @(posedge Clock); #1;
      cyc++;
    end
    Start = 1'b0; Abort = 1'b0; Stall = 1'b0;
    check("done_seen", Done, 1);
    check("done_latency", cyc, n + stalls + 1 + aborted);
    check("accepted_count", acc, n);
    check("busy_low_on_done", Busy, 0);
    // Start and Abort during the DONE cycle must be ignored.
    Start = 1'b1; Abort = 1'($urandom); Mode = 1'($urandom);
    X0 = XW'($urandom_range(20)); Y0 = YW'($urandom_range(20)); W = XW'($urandom_range(5)); H = YW'($urandom_range(5));
    @(posedge Clock); #1;
    Start = 1'b0; Abort = 1'b0;
    check("idle_after_done", {Busy, Plot, Done}, 0);
  endtask

  initial begin
    int n;
    #22;
    check("rst_x", X, 0); check("rst_y", Y, 0); check("rst_color", ColorOut, 0);
    check("rst_plot", Plot, 0); check("rst_busy", Busy, 0); check("rst_done", Done, 0);
    #6 Reset = 1'b0;
    @(posedge Clock); #1;

    run_req(0, 0, 0, 0, 0, 0, 0, 0, -1, -1, 0, -1, 0);          // full-screen CLEAR
    run_req(1, 5, 5, 10, 40, 5, 0, 0, -1, -1, 0, -1, 0);        // FILL 10x40
    run_req(1, 155, 118, 10, 10, 3, 0, 0, -1, -1, 0, -1, 0);    // clipped corner
    run_req(1, 200, 5, 5, 5, 1, 0, 0, -1, -1, 0, -1, 0);        // X0 off screen
    run_req(1, 10, 10, 0, 5, 1, 0, 0, -1, -1, 0, -1, 0);        // W = 0
    run_req(1, 10, 10, 5, 0, 1, 0, 0, -1, -1, 0, -1, 0);        // H = 0
    run_req(1, 10, 120, 5, 5, 1, 0, 0, -1, -1, 0, -1, 0);       // Y0 = SCREEN_H
    run_req(1, 150, 100, 511, 255, 6, 0, 0, -1, -1, 0, -1, 0);  // sums exceed XW/YW bits
    run_req(1, 0, 0, 3, 2, 4, 0, 0, -1, 1, 2, 5, 1);            // directed back-pressure
    run_req(0, 0, 0, 0, 0, 0, 2, 0, 7, -1, 0, -1, 0);           // CLEAR aborted after 7
    run_req(1, 30, 40, 6, 4, 7, 0, 0, -1, -1, 0, -1, 0);        // normal after abort

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(4) == 0)
        run_req(0, 0, 0, 0, 0, 0, $urandom_range(7), 25, $urandom_range(40), -1, 0, -1, 0);
      else
        run_req(1, $urandom_range(175), $urandom_range(130), $urandom_range(25), $urandom_range(20),
                $urandom_range(7), $urandom_range(7), 25, -1, -1, 0, -1, 0);
    end

    // Asynchronous reset in the middle of a sweep.
    push_req(0, 0, 0, 0, 0, 0, 5, -1, n);
    Mode = 1'b0; BgColor = 3'd5; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (20) @(posedge Clock);
    #4 Reset = 1'b1;
    #1;
    check("arst_x", X, 0); check("arst_y", Y, 0); check("arst_color", ColorOut, 0);
    check("arst_plot", Plot, 0); check("arst_busy", Busy, 0); check("arst_done", Done, 0);
    sb.delete();
    @(posedge Clock); #3 Reset = 1'b0;
    @(posedge Clock); #1;
    check("post_rst_idle", {Busy, Plot, Done}, 0);
    run_req(1, 20, 30, 4, 3, 6, 0, 20, -1, -1, 0, -1, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
